// File: rtl/btb_resolve_ctrl.sv
// BTB return path: tracks in-flight predictions in order, resolves them against EX, drives BTB update and redirect.
// Latency: update/redirect registered one cycle after the pop edge. Backpressure: fifo_full stalls IF; wrong-path work dropped in REDIRECT.
// Optional BTB_STATS_EN adds stat_branches/stat_mispredicts counters.
module btb_resolve_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        fifo_full,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update,
    output logic [31:0] update_pc,
    output logic [31:0] update_target,
    output logic        mispredicted,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        underflow_err
`ifdef BTB_STATS_EN
   ,output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {RUN, REDIRECT} state_t;

    logic [31:0] pc_mem  [DEPTH];
    logic        pv_mem  [DEPTH];
    logic        pt_mem  [DEPTH];
    logic [31:0] tgt_mem [DEPTH];

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          update_q, mispredicted_q, redirect_q, underflow_q;
    logic [31:0]   update_pc_q, update_target_q, redirect_pc_q;

    logic        pop_c, push_c, mis_c, mis_pop, upd_c, run_c;
    logic [31:0] head_pc, head_tgt, pred_npc, act_npc;
    logic        head_pv, head_pt;

    always_comb begin
        head_pc  = pc_mem[rd_ptr_q];
        head_pv  = pv_mem[rd_ptr_q];
        head_pt  = pt_mem[rd_ptr_q];
        head_tgt = tgt_mem[rd_ptr_q];
        run_c    = (state_q == RUN);
        pred_npc = (head_pv && head_pt) ? head_tgt : head_pc + 32'd4;
        act_npc  = (ex_is_branch && ex_taken) ? ex_target : head_pc + 32'd4;
        mis_c    = (pred_npc != act_npc);
        pop_c    = ex_valid && (count_q != '0) && run_c;
        mis_pop  = pop_c && mis_c;
        upd_c    = pop_c && (ex_is_branch || head_pv);
        // A mispredict in the same cycle makes the incoming fetch wrong-path.
        push_c   = fetch_valid && ((count_q != FULL_CNT) || pop_c) && run_c && !mis_pop;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            RUN:      if (mis_pop) state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (mis_pop) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_c && !pop_c)      count_d = count_q + CW'(1);
            else if (!push_c && pop_c) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[wr_ptr_q]  <= fetch_pc;
            pv_mem[wr_ptr_q]  <= pred_valid;
            pt_mem[wr_ptr_q]  <= pred_taken;
            tgt_mem[wr_ptr_q] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= RUN;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            update_q        <= 1'b0;
            update_pc_q     <= '0;
            update_target_q <= '0;
            mispredicted_q  <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            underflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            update_q       <= upd_c;
            mispredicted_q <= mis_pop;
            redirect_q     <= mis_pop;
            if (upd_c) begin
                update_pc_q     <= head_pc;
                update_target_q <= ex_is_branch ? ex_target : head_tgt;
            end
            if (mis_pop) redirect_pc_q <= act_npc;
            if (ex_valid && (count_q == '0) && run_c) underflow_q <= 1'b1;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (upd_c && ex_is_branch) stat_br_q <= stat_br_q + 32'd1;
            if (mis_pop)               stat_mp_q <= stat_mp_q + 32'd1;
        end
    end
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

    assign fifo_full     = (count_q == FULL_CNT);
    assign update        = update_q;
    assign update_pc     = update_pc_q;
    assign update_target = update_target_q;
    assign mispredicted  = mispredicted_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign underflow_err = underflow_q;
endmodule

// File: tb/tb_btb_resolve_ctrl.sv
// Bench for btb_resolve_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_btb_resolve_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, pred_valid, pred_taken;
    logic [31:0] fetch_pc, pred_target;
    logic        ex_valid, ex_is_branch, ex_taken;
    logic [31:0] ex_target;
    logic        fifo_full, update, mispredicted, redirect, underflow_err;
    logic [31:0] update_pc, update_target, redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    btb_resolve_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .fifo_full(fifo_full),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .update(update), .update_pc(update_pc), .update_target(update_target),
        .mispredicted(mispredicted), .redirect(redirect), .redirect_pc(redirect_pc),
        .underflow_err(underflow_err)
`ifdef BTB_STATS_EN
       ,.stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pv;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    bit          m_redir;
    logic        exp_update, exp_mis, exp_redir, exp_uf, exp_full;
    logic [31:0] exp_upc, exp_utgt, exp_rpc, m_br, m_mp;
    int          checks = 0;
    int          errors = 0;

    task automatic m_reset();
        q.delete();
        m_redir = 0;
        exp_update = 0; exp_mis = 0; exp_redir = 0; exp_uf = 0; exp_full = 0;
        exp_upc = 0; exp_utgt = 0; exp_rpc = 0; m_br = 0; m_mp = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic pv, input logic pt,
                        input logic [31:0] ptg, input logic exv, input logic exb, input logic ext,
                        input logic [31:0] etg);
        bit run, pop, mis, upd, push;
        int sz;
        logic [31:0] pn, an;
        ent_t h, e;
        fetch_valid = fv; fetch_pc = fpc; pred_valid = pv; pred_taken = pt; pred_target = ptg;
        ex_valid = exv; ex_is_branch = exb; ex_taken = ext; ex_target = etg;
        run = !m_redir;
        sz  = q.size();
        pop = exv && sz != 0 && run;
        mis = 0; upd = 0; an = 0;
        if (exv && sz == 0 && run) exp_uf = 1;
        if (pop) begin
            h  = q.pop_front();
            pn = (h.pv && h.pt) ? h.tgt : h.pc + 32'd4;
            an = (exb && ext) ? etg : h.pc + 32'd4;
            mis = (pn != an);
            upd = exb || h.pv;
            if (upd) begin
                exp_upc  = h.pc;
                exp_utgt = exb ? etg : h.tgt;
                if (exb) m_br = m_br + 1;
            end
        end
        push = fv && (sz < DEPTH || pop) && run && !mis;
        exp_update = upd;
        exp_mis    = mis;
        exp_redir  = mis;
        if (mis) begin
            q.delete();
            m_redir = 1;
            exp_rpc = an;
            m_mp = m_mp + 1;
        end else begin
            m_redir = 0;
        end
        if (push) begin
            e.pc = fpc; e.pv = pv; e.pt = pt; e.tgt = ptg;
            q.push_back(e);
        end
        exp_full = (q.size() == DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 0;
        m_reset();
        idle();
        idle();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        m_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({update, mispredicted, redirect, fifo_full, underflow_err, update_pc, update_target, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got upd=%0b mis=%0b red=%0b full=%0b uf=%0b upc=%h utgt=%h rpc=%h required all 0",
                     update, mispredicted, redirect, fifo_full, underflow_err, update_pc, update_target, redirect_pc);
        end
`ifdef BTB_STATS_EN
        checks++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d required 0/0", stat_branches, stat_mispredicts);
        end
`endif
        rst = 1;
    endtask

    task automatic test_no_hit_pop();
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (update !== 1'b0 || redirect !== 1'b0 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL nohit_pop got upd=%0b red=%0b full=%0b required 0 0 0", update, redirect, fifo_full);
        end
    endtask

    task automatic test_hit_correct();
        step(1, 32'h200, 1, 1, 32'h300, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h300);
        checks++;
        if (update !== 1'b1 || update_pc !== 32'h200 || update_target !== 32'h300 ||
            mispredicted !== 1'b0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL hit_correct got upd=%0b pc=%h tgt=%h mis=%0b red=%0b required 1 200 300 0 0",
                     update, update_pc, update_target, mispredicted, redirect);
        end
    endtask

    task automatic test_redirect();
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h48, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h4C, 0, 0, 0, 1, 1, 1, 32'h80);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80 || mispredicted !== 1'b1 || update !== 1'b1 ||
            update_pc !== 32'h40 || update_target !== 32'h80) begin
            errors++;
            $display("FAIL redirect_taken got red=%0b rpc=%h mis=%0b upd=%0b upc=%h utgt=%h required 1 80 1 1 40 80",
                     redirect, redirect_pc, mispredicted, update, update_pc, update_target);
        end
        step(1, 32'h80, 1, 1, 32'h90, 1, 1, 1, 32'h90);
        checks++;
        if (update !== 1'b0 || redirect !== 1'b0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL redirect_state_ignored got upd=%0b red=%0b uf=%0b required 0 0 0", update, redirect, underflow_err);
        end
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'hA0);
        checks++;
        if (update !== 1'b0 || underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL redirect_fifo_empty got upd=%0b uf=%0b required 0 1", update, underflow_err);
        end
    endtask

    task automatic test_false_hit();
        step(1, 32'h10, 1, 1, 32'h50, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h1234);
        checks++;
        if (update !== 1'b1 || update_pc !== 32'h10 || update_target !== 32'h50 || mispredicted !== 1'b1 ||
            redirect !== 1'b1 || redirect_pc !== 32'h14) begin
            errors++;
            $display("FAIL false_hit got upd=%0b pc=%h tgt=%h mis=%0b red=%0b rpc=%h required 1 10 50 1 1 14",
                     update, update_pc, update_target, mispredicted, redirect, redirect_pc);
        end
        idle();
        checks++;
        if (redirect !== 1'b0 || update !== 1'b0) begin
            errors++;
            $display("FAIL redirect_pulse_width got red=%0b upd=%0b required 0 0", redirect, update);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) step(1, 32'h600 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_after_fill got %0b required 1", fifo_full);
        end
        step(1, 32'h700, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (fifo_full !== 1'b1 || update !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got full=%0b upd=%0b required 1 0", fifo_full, update);
        end
        step(1, 32'h704, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_pop got %0b required 0", fifo_full);
        end
        // Remaining entries in order: 0x608, 0x60C, 0x700; the dropped 0x704 must never surface.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (update !== 1'b1 || update_pc !== 32'h700 || exp_upc !== 32'h700) begin
            errors++;
            $display("FAIL full_order got pc=%h required 700", update_pc);
        end
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        checks++;
        if (update !== 1'b0 || underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL full_drop_sticky got upd=%0b uf=%0b required 0 1", update, underflow_err);
        end
    endtask

    task automatic test_reset_midstream();
        step(1, 32'h900, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'hC00);
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'hC00) begin
            errors++;
            $display("FAIL pre_reset_redirect got red=%0b rpc=%h required 1 c00", redirect, redirect_pc);
        end
        #2 rst = 0;
        #1;
        checks++;
        if ({update, mispredicted, redirect, fifo_full, underflow_err, update_pc, update_target, redirect_pc} !== '0) begin
            errors++;
            $display("FAIL async_reset got upd=%0b mis=%0b red=%0b full=%0b uf=%0b rpc=%h required all 0",
                     update, mispredicted, redirect, fifo_full, underflow_err, redirect_pc);
        end
`ifdef BTB_STATS_EN
        checks++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            errors++;
            $display("FAIL async_reset_stats got %0d/%0d required 0/0", stat_branches, stat_mispredicts);
        end
`endif
        m_reset();
        @(posedge clk);
        #1 rst = 1;
        for (int i = 0; i < DEPTH; i++) step(1, 32'hA00 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 0;
        #1;
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_full got %0b required 0", fifo_full);
        end
        m_reset();
        @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic test_random();
        logic [31:0] pool [4];
        pool[0] = 32'h400; pool[1] = 32'h404; pool[2] = 32'h800; pool[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, 32'($urandom_range(0, 63)) << 2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                 $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pool[$urandom_range(0, 3)]);
            checks++;
            if (update !== exp_update || mispredicted !== exp_mis || redirect !== exp_redir ||
                fifo_full !== exp_full || underflow_err !== exp_uf) begin
                errors++;
                $display("FAIL rnd_flags step %0d got upd=%0b mis=%0b red=%0b full=%0b uf=%0b required %0b %0b %0b %0b %0b",
                         i, update, mispredicted, redirect, fifo_full, underflow_err,
                         exp_update, exp_mis, exp_redir, exp_full, exp_uf);
            end
            if (exp_update) begin
                checks++;
                if (update_pc !== exp_upc || update_target !== exp_utgt) begin
                    errors++;
                    $display("FAIL rnd_update step %0d got pc=%h tgt=%h required %h %h",
                             i, update_pc, update_target, exp_upc, exp_utgt);
                end
            end
            if (exp_redir) begin
                checks++;
                if (redirect_pc !== exp_rpc) begin
                    errors++;
                    $display("FAIL rnd_redirect_pc step %0d got %h required %h", i, redirect_pc, exp_rpc);
                end
            end
`ifdef BTB_STATS_EN
            checks++;
            if (stat_branches !== m_br || stat_mispredicts !== m_mp) begin
                errors++;
                $display("FAIL rnd_stats step %0d got %0d/%0d required %0d/%0d",
                         i, stat_branches, stat_mispredicts, m_br, m_mp);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_no_hit_pop();
        test_hit_correct();
        test_redirect();
        test_false_hit();
        test_full();
        test_reset_midstream();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
